cnn_window_gen: RTL and testbench

Sliding-window generator at the head of the pooling path. It takes a raster-order stream of 32-bit feature-map pixels and buffers the previous K-1 rows in line buffers. For every non-overlapping KxK tile (stride = K) it emits one packed window on the window_valid/window/window_stall interface consumed by CNNPool. It is the producer end of that interface: it holds each window stable while the pool stalls, and back-pressures the pixel source.

---
 rtl/cnn_window_gen_pkg.sv | 26 ++
 rtl/cnn_window_gen_line_buffer.sv | 22 ++
 rtl/cnn_window_gen.sv | 181 ++++++++++++++++++
 tb/tb_cnn_window_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_window_gen_pkg.sv
// Shared constants, kernel-select encodings and FSM states for the pooling-path
// sliding-window generator.
package cnn_window_gen_pkg;

  localparam int MAX_K       = 3;
  localparam int WINDOW_SIZE = MAX_K * MAX_K;
  localparam int KERNEL_SIZE = 3;

  localparam logic [KERNEL_SIZE-1:0] KSEL_2 = 3'b010;
  localparam logic [KERNEL_SIZE-1:0] KSEL_3 = 3'b100;

  typedef enum logic [1:0] {
    WG_IDLE  = 2'd0,
    WG_RUN   = 2'd1,
    WG_DRAIN = 2'd2
  } wg_state_t;

  // Kernel edge length from the two one-hot fields; 0 marks an unsupported pair.
  function automatic logic [1:0] decode_k(input logic [KERNEL_SIZE-1:0] kh,
                                          input logic [KERNEL_SIZE-1:0] kw);
    if (kh == KSEL_2 && kw == KSEL_2) return 2'd2;
    if (kh == KSEL_3 && kw == KSEL_3) return 2'd3;
    return 2'd0;
  endfunction

endpackage

// File: rtl/cnn_window_gen_line_buffer.sv
// One image row of 32-bit pixels: synchronous write, combinational read at the
// same column index so the old value can be forwarded while it is replaced.
module cnn_window_gen_line_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/cnn_window_gen.sv
// Raster-stream to non-overlapping KxK window generator (K = 2 or 3, stride K)
// feeding the pool stage through a valid/stall producer interface.
module cnn_window_gen
  import cnn_window_gen_pkg::*;
#(
  parameter int MAX_WIDTH = 64,
  parameter int DIM_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_conf_refresh,
  input  logic [KERNEL_SIZE-1:0]    i_kernel_height,
  input  logic [KERNEL_SIZE-1:0]    i_kernel_width,
  input  logic [DIM_W-1:0]          i_img_width,
  input  logic [DIM_W-1:0]          i_img_height,
  input  logic                      i_pix_valid,
  input  logic [31:0]               i_pix_data,
  output logic                      o_pix_ready,
  output logic                      o_window_valid,
  output logic [WINDOW_SIZE*32-1:0] o_window,
  input  logic                      i_window_stall,
  output logic                      o_frame_done,
  output wg_state_t                 o_state
);

  // Handshakes: a pixel moves when i_pix_valid & o_pix_ready; a window moves
  // when o_window_valid & ~i_window_stall, and is held unchanged until then.

  localparam int LB_AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  wg_state_t                r_state;
  logic [1:0]               r_k;
  logic [DIM_W-1:0]         r_width, r_height, r_col, r_row;
  logic [1:0]               r_col_mod, r_row_mod;
  logic                     r_window_valid, r_frame_done;
  logic [WINDOW_SIZE*32-1:0] r_window;
  logic [31:0]              r_sr [MAX_K][MAX_K];

  logic [31:0]              w_lb_rd [MAX_K-1];
  logic [31:0]              w_lb_wr [MAX_K-1];
  logic [31:0]              w_col_in [MAX_K];
  logic [31:0]              w_sr_next [MAX_K][MAX_K];
  logic [WINDOW_SIZE*32-1:0] w_win2, w_win3, w_window;
  logic [DIM_W-1:0]         w_width_cfg, w_height_cfg;
  logic [1:0]               w_km1;
  logic                     w_pix_ready, w_accept, w_xfer, w_emit;
  logic                     w_last_col, w_last_pix;

  assign w_pix_ready = (r_state == WG_RUN) && !(r_window_valid && i_window_stall)
                       && !i_conf_refresh;
  assign w_accept    = w_pix_ready && i_pix_valid;
  assign w_xfer      = r_window_valid && !i_window_stall;
  assign w_km1       = r_k - 2'd1;
  assign w_last_col  = (r_col == r_width - 1'b1);
  assign w_last_pix  = w_last_col && (r_row == r_height - 1'b1);
  // A tile that closes at c%K == K-1 always fits inside the image, so the
  // trailing partial tiles drop out without an explicit bound check.
  assign w_emit      = w_accept && (r_k != 2'd0) && (r_col_mod == w_km1)
                       && (r_row_mod == w_km1);

  always_comb begin
    w_width_cfg = i_img_width;
    if (i_img_width == '0)                     w_width_cfg = 1;
    else if (i_img_width > DIM_W'(MAX_WIDTH))  w_width_cfg = DIM_W'(MAX_WIDTH);
    w_height_cfg = (i_img_height == '0) ? DIM_W'(1) : i_img_height;
  end

  // Line buffer j holds row r-1-j; each write pushes the displaced pixel down.
  for (genvar j = 0; j < MAX_K-1; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign w_lb_wr[j] = i_pix_data;
    end else begin : g_tail
      assign w_lb_wr[j] = w_lb_rd[j-1];
    end
    cnn_window_gen_line_buffer #(.DEPTH(MAX_WIDTH), .AW(LB_AW)) u_lb (
      .clk     (clk),
      .i_we    (w_accept),
      .i_addr  (r_col[LB_AW-1:0]),
      .i_wdata (w_lb_wr[j]),
      .o_rdata (w_lb_rd[j])
    );
    assign w_col_in[MAX_K-2-j] = w_lb_rd[j];
  end
  assign w_col_in[MAX_K-1] = i_pix_data;

  // Column shift register: row index 0 is the oldest row, column MAX_K-1 newest.
  for (genvar rr = 0; rr < MAX_K; rr++) begin : g_sr_row
    for (genvar cc = 0; cc < MAX_K-1; cc++) begin : g_sr_col
      assign w_sr_next[rr][cc] = r_sr[rr][cc+1];
    end
    assign w_sr_next[rr][MAX_K-1] = w_col_in[rr];
  end

  for (genvar rr = 0; rr < MAX_K; rr++) begin : g_w3_row
    for (genvar cc = 0; cc < MAX_K; cc++) begin : g_w3_col
      assign w_win3[(rr*MAX_K+cc)*32 +: 32] = w_sr_next[rr][cc];
    end
  end
  for (genvar rr = 0; rr < 2; rr++) begin : g_w2_row
    for (genvar cc = 0; cc < 2; cc++) begin : g_w2_col
      assign w_win2[(rr*2+cc)*32 +: 32] = w_sr_next[MAX_K-2+rr][MAX_K-2+cc];
    end
  end
  assign w_win2[WINDOW_SIZE*32-1:4*32] = '0;
  assign w_window = (r_k == 2'd3) ? w_win3 : w_win2;

  always_ff @(posedge clk) begin
    if (w_accept) r_sr <= w_sr_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= WG_IDLE;
      r_k            <= '0;
      r_width        <= '0;
      r_height       <= '0;
      r_col          <= '0;
      r_row          <= '0;
      r_col_mod      <= '0;
      r_row_mod      <= '0;
      r_window_valid <= 1'b0;
      r_window       <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (i_conf_refresh) begin
        r_k            <= decode_k(i_kernel_height, i_kernel_width);
        r_width        <= w_width_cfg;
        r_height       <= w_height_cfg;
        r_col          <= '0;
        r_row          <= '0;
        r_col_mod      <= '0;
        r_row_mod      <= '0;
        r_window_valid <= 1'b0;
        r_state        <= WG_RUN;
      end else begin
        if (w_emit) begin
          r_window_valid <= 1'b1;
          r_window       <= w_window;
        end else if (w_xfer) begin
          r_window_valid <= 1'b0;
        end
        case (r_state)
          WG_RUN: begin
            if (w_accept) begin
              if (w_last_pix) begin
                r_col     <= '0;
                r_row     <= '0;
                r_col_mod <= '0;
                r_row_mod <= '0;
                r_state   <= WG_DRAIN;
              end else if (w_last_col) begin
                r_col     <= '0;
                r_col_mod <= '0;
                r_row     <= r_row + 1'b1;
                r_row_mod <= (r_k == 2'd0 || r_row_mod == w_km1) ? 2'd0 : r_row_mod + 2'd1;
              end else begin
                r_col     <= r_col + 1'b1;
                r_col_mod <= (r_k == 2'd0 || r_col_mod == w_km1) ? 2'd0 : r_col_mod + 2'd1;
              end
            end
          end
          WG_DRAIN: begin
            if (!r_window_valid || w_xfer) begin
              r_frame_done <= 1'b1;
              r_state      <= WG_RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_pix_ready    = w_pix_ready;
  assign o_window_valid = r_window_valid;
  assign o_window       = r_window;
  assign o_frame_done   = r_frame_done;
  assign o_state        = r_state;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Bench for cnn_window_gen: directed and random frames checked cycle by cycle
// against a frame-array reference model with an expected-window queue.
module tb_cnn_window_gen;
  import cnn_window_gen_pkg::*;

  localparam int WB = WINDOW_SIZE * 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_conf_refresh;
  logic [KERNEL_SIZE-1:0] i_kernel_height, i_kernel_width;
  logic [7:0]             i_img_width, i_img_height;
  logic                   i_pix_valid;
  logic [31:0]            i_pix_data;
  logic                   o_pix_ready;
  logic                   o_window_valid;
  logic [WB-1:0]          o_window;
  logic                   i_window_stall;
  logic                   o_frame_done;
  wg_state_t              o_state;

  cnn_window_gen dut (
    .clk             (clk),
    .rst             (rst),
    .i_conf_refresh  (i_conf_refresh),
    .i_kernel_height (i_kernel_height),
    .i_kernel_width  (i_kernel_width),
    .i_img_width     (i_img_width),
    .i_img_height    (i_img_height),
    .i_pix_valid     (i_pix_valid),
    .i_pix_data      (i_pix_data),
    .o_pix_ready     (o_pix_ready),
    .o_window_valid  (o_window_valid),
    .o_window        (o_window),
    .i_window_stall  (i_window_stall),
    .o_frame_done    (o_frame_done),
    .o_state         (o_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the frame as a 2-D array plus the queue of windows owed.
  logic [31:0]   img [0:63][0:63];
  logic [WB-1:0] exp_q [$];
  logic [WB-1:0] obs_q [$];
  int            m_k, m_w, m_h, m_idx;
  wg_state_t     m_mode;
  bit            m_done;
  int            dut_done_cnt;

  task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WB-1:0] win4(input int a, input int b, input int c, input int d);
    logic [WB-1:0] w;
    w = '0;
    w[31:0] = 32'(a); w[63:32] = 32'(b); w[95:64] = 32'(c); w[127:96] = 32'(d);
    return w;
  endfunction

  function automatic logic [WB-1:0] win9(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5,
                                         input int a6, input int a7, input int a8);
    logic [WB-1:0] w;
    w = '0;
    w[31:0]    = 32'(a0); w[63:32]   = 32'(a1); w[95:64]   = 32'(a2);
    w[127:96]  = 32'(a3); w[159:128] = 32'(a4); w[191:160] = 32'(a5);
    w[223:192] = 32'(a6); w[255:224] = 32'(a7); w[287:256] = 32'(a8);
    return w;
  endfunction

  // KxK tile whose bottom-right pixel is (r,c), oldest row first, left to right.
  function automatic logic [WB-1:0] window_at(input int r, input int c);
    logic [WB-1:0] w;
    w = '0;
    for (int rr = 0; rr < m_k; rr++)
      for (int cc = 0; cc < m_k; cc++)
        w[(rr*m_k+cc)*32 +: 32] = img[r-m_k+1+rr][c-m_k+1+cc];
    return w;
  endfunction

  // One clock: drive, check the DUT against the model, advance the model.
  task automatic tick(input bit v, input bit s, input bit cr, input logic [31:0] d);
    bit ev, er, xfer;
    int r, c;
    i_pix_valid = v; i_pix_data = d; i_window_stall = s; i_conf_refresh = cr;
    #1;
    ev = (exp_q.size() != 0);
    er = (m_mode == WG_RUN) && !(ev && s) && !cr;
    chk("pix_ready", WB'(o_pix_ready), WB'(er));
    chk("window_valid", WB'(o_window_valid), WB'(ev));
    if (ev) chk("window", o_window, exp_q[0]);
    chk("frame_done", WB'(o_frame_done), WB'(m_done));
    chk("state", WB'(o_state), WB'(m_mode));
    if (o_frame_done === 1'b1) dut_done_cnt++;
    if (o_window_valid === 1'b1 && !s) obs_q.push_back(o_window);
    m_done = 1'b0;
    if (cr) begin
      if (i_kernel_height == KSEL_2 && i_kernel_width == KSEL_2)      m_k = 2;
      else if (i_kernel_height == KSEL_3 && i_kernel_width == KSEL_3) m_k = 3;
      else                                                            m_k = 0;
      m_w = (i_img_width == 0) ? 1 : int'(i_img_width);
      m_h = (i_img_height == 0) ? 1 : int'(i_img_height);
      exp_q.delete();
      m_mode = WG_RUN;
      m_idx = 0;
    end else begin
      xfer = ev && !s;
      if (xfer) void'(exp_q.pop_front());
      if (m_mode == WG_RUN && er && v) begin
        r = m_idx / m_w;
        c = m_idx % m_w;
        img[r][c] = d;
        if (m_k != 0 && r % m_k == m_k-1 && c % m_k == m_k-1 &&
            r < (m_h/m_k)*m_k && c < (m_w/m_k)*m_k)
          exp_q.push_back(window_at(r, c));
        m_idx++;
        if (m_idx == m_w*m_h) m_mode = WG_DRAIN;
      end else if (m_mode == WG_DRAIN && (!ev || xfer)) begin
        m_done = 1'b1;
        m_mode = WG_RUN;
        m_idx = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic configure(input logic [KERNEL_SIZE-1:0] kh, input logic [KERNEL_SIZE-1:0] kw,
                           input int w, input int h);
    i_kernel_height = kh; i_kernel_width = kw;
    i_img_width = 8'(w); i_img_height = 8'(h);
    obs_q.delete();
    dut_done_cnt = 0;
    tick(1'b0, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic run_frame(input logic [KERNEL_SIZE-1:0] kh, input logic [KERNEL_SIZE-1:0] kw,
                           input int w, input int h, input bit seq, input int stall_pct,
                           input int valid_pct, input int stall_first, input int exp_windows,
                           input string tag);
    int budget, nst;
    bit v, s;
    configure(kh, kw, w, h);
    budget = 0;
    nst = 0;
    while (!m_done && budget < 8000) begin
      v = ($urandom_range(99) < valid_pct);
      if (stall_first > 0 && exp_q.size() != 0 && obs_q.size() == 0 && nst < stall_first) begin
        s = 1'b1;
        nst++;
      end else begin
        s = ($urandom_range(99) < stall_pct);
      end
      tick(v, s, 1'b0, seq ? 32'(m_idx) : $urandom());
      budget++;
    end
    chk({tag, "_budget"}, WB'(m_done), WB'(1));
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 32'd0);
    chk({tag, "_window_count"}, WB'(obs_q.size()), WB'(exp_windows));
    chk({tag, "_frame_done_count"}, WB'(dut_done_cnt), WB'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pix_ready"}, WB'(o_pix_ready), WB'(0));
    chk({tag, "_window_valid"}, WB'(o_window_valid), WB'(0));
    chk({tag, "_window"}, o_window, '0);
    chk({tag, "_frame_done"}, WB'(o_frame_done), WB'(0));
    chk({tag, "_state"}, WB'(o_state), WB'(WG_IDLE));
  endtask

  initial begin
    int k, w, h, we, tries;
    rst = 1'b1;
    i_conf_refresh = 1'b0; i_kernel_height = '0; i_kernel_width = '0;
    i_img_width = '0; i_img_height = '0;
    i_pix_valid = 1'b0; i_pix_data = '0; i_window_stall = 1'b0;
    m_k = 0; m_w = 1; m_h = 1; m_idx = 0; m_mode = WG_IDLE; m_done = 1'b0;
    dut_done_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // IDLE must refuse pixels until configured.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 32'hdead);

    run_frame(KSEL_2, KSEL_2, 4, 4, 1'b1, 0, 100, 0, 4, "k2_4x4");
    chk("k2_4x4_first", obs_q[0], win4(0, 1, 4, 5));
    chk("k2_4x4_second", obs_q[1], win4(2, 3, 6, 7));
    chk("k2_4x4_last", obs_q[3], win4(10, 11, 14, 15));

    run_frame(KSEL_3, KSEL_3, 6, 6, 1'b1, 0, 100, 0, 4, "k3_6x6");
    chk("k3_6x6_first", obs_q[0], win9(0, 1, 2, 6, 7, 8, 12, 13, 14));
    chk("k3_6x6_last", obs_q[3], win9(21, 22, 23, 27, 28, 29, 33, 34, 35));

    run_frame(KSEL_2, KSEL_2, 4, 4, 1'b1, 0, 100, 3, 4, "k2_stall");
    chk("k2_stall_first", obs_q[0], win4(0, 1, 4, 5));
    chk("k2_stall_third", obs_q[2], win4(8, 9, 12, 13));

    run_frame(KSEL_2, KSEL_2, 5, 5, 1'b1, 0, 100, 0, 4, "k2_5x5");
    chk("k2_5x5_first", obs_q[0], win4(0, 1, 5, 6));
    chk("k2_5x5_last", obs_q[3], win4(12, 13, 17, 18));

    // Reset in the middle of a frame while a window is held by a stall.
    configure(KSEL_2, KSEL_2, 4, 4);
    tries = 0;
    while (exp_q.size() == 0 && tries < 20) begin
      tick(1'b1, 1'b1, 1'b0, 32'(m_idx));
      tries++;
    end
    chk("midrst_window_pending", WB'(o_window_valid), WB'(1));
    i_pix_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    exp_q.delete();
    m_mode = WG_IDLE; m_done = 1'b0; m_idx = 0;
    tick(1'b1, 1'b0, 1'b0, 32'd7);
    run_frame(KSEL_2, KSEL_2, 4, 4, 1'b1, 0, 100, 0, 4, "after_rst");
    chk("after_rst_first", obs_q[0], win4(0, 1, 4, 5));

    run_frame(KSEL_2, KSEL_3, 4, 4, 1'b1, 0, 100, 0, 0, "illegal_k");

    run_frame(KSEL_3, KSEL_3, 64, 3, 1'b0, 20, 80, 0, 21, "k3_max_width");
    run_frame(KSEL_2, KSEL_2, 0, 0, 1'b0, 0, 100, 0, 0, "zero_dims");

    for (int n = 0; n < 10; n++) begin
      k = $urandom_range(0, 1) ? 3 : 2;
      w = $urandom_range(0, 12);
      h = $urandom_range(1, 8);
      we = (w == 0) ? 1 : w;
      run_frame((k == 3) ? KSEL_3 : KSEL_2, (k == 3) ? KSEL_3 : KSEL_2, w, h, 1'b0,
                30, 70, 0, (h/k)*(we/k), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
